// File: rtl/sample_frame_counter.sv
// Registers the complex sample stream and tags each accepted sample with global,
// frame and in-frame indices plus SOF/EOF; flags capture completion and overrun.
module sample_frame_counter #(
   parameter  int I_BW       = 14,
   parameter  int O_BW       = 14,
   parameter  int FRAME_LEN  = 512,
   parameter  int TOTAL_DATA = 91136,
   localparam int NB_W       = $clog2(FRAME_LEN),
   localparam int N_FRAMES   = (TOTAL_DATA + FRAME_LEN - 1) / FRAME_LEN,
   localparam int NF_W       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
   localparam int NT_W       = $clog2(TOTAL_DATA)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   di_en,
   input  logic [I_BW-1:0]        di_re,
   input  logic [I_BW-1:0]        di_im,
   output logic                   do_en,
   output logic [O_BW-1:0]        do_re,
   output logic [O_BW-1:0]        do_im,
   output logic                   do_sof,
   output logic                   do_eof,
   output logic [NT_W-1:0]        num,
   output logic [NF_W-1:0]        frame_idx,
   output logic [NB_W-1:0]        bin_idx,
   output logic                   done,
   output logic                   ovf
);

   logic [NT_W-1:0] t;
   logic [NB_W-1:0] b;
   logic [NF_W-1:0] f;
   logic [O_BW-1:0] re_c, im_c;
   logic            acc, b_last, t_last;

   generate
      if (O_BW >= I_BW) begin : g_ext
         assign re_c = O_BW'($signed(di_re));
         assign im_c = O_BW'($signed(di_im));
      end else begin : g_trunc
         assign re_c = di_re[I_BW-1 -: O_BW];
         assign im_c = di_im[I_BW-1 -: O_BW];
      end
   endgenerate

   assign acc    = di_en & ~done & ~clr;
   assign b_last = (b == NB_W'(FRAME_LEN - 1));
   assign t_last = (t == NT_W'(TOTAL_DATA - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t         <= '0;
         b         <= '0;
         f         <= '0;
         do_en     <= 1'b0;
         do_re     <= '0;
         do_im     <= '0;
         do_sof    <= 1'b0;
         do_eof    <= 1'b0;
         num       <= '0;
         frame_idx <= '0;
         bin_idx   <= '0;
         done      <= 1'b0;
         ovf       <= 1'b0;
      end else if (clr) begin
         t     <= '0;
         b     <= '0;
         f     <= '0;
         do_en <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         do_en <= acc;
         if (di_en && done)
            ovf <= 1'b1;
         if (acc) begin
            do_re     <= re_c;
            do_im     <= im_c;
            num       <= t;
            bin_idx   <= b;
            frame_idx <= f;
            do_sof    <= (b == '0);
            do_eof    <= b_last | t_last;
            // Counters freeze on the last sample so they never step past the capture.
            if (t_last) begin
               done <= 1'b1;
            end else begin
               t <= t + NT_W'(1);
               if (b_last) begin
                  b <= '0;
                  f <= f + NF_W'(1);
               end else begin
                  b <= b + NB_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_frame_counter.sv
// Randomized bench for sample_frame_counter (FRAME_LEN=4, TOTAL_DATA=10) with a
// count-based reference model and two output widths (truncating and sign-extending).
module tb_sample_frame_counter;

   localparam int FL = 4;
   localparam int TD = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic di_en = 1'b0;
   logic [13:0] di_re = '0, di_im = '0;

   logic        a_en, a_sof, a_eof, a_done, a_ovf;
   logic [9:0]  a_re, a_im;
   logic [3:0]  a_num;
   logic [1:0]  a_frame, a_bin;
   logic        w_en, w_sof, w_eof, w_done, w_ovf;
   logic [15:0] w_re, w_im;
   logic [3:0]  w_num;
   logic [1:0]  w_frame, w_bin;

   sample_frame_counter #(.I_BW(14), .O_BW(10), .FRAME_LEN(FL), .TOTAL_DATA(TD)) dut (
      .clk(clk), .rst(rst), .clr(clr), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(a_en), .do_re(a_re), .do_im(a_im), .do_sof(a_sof), .do_eof(a_eof),
      .num(a_num), .frame_idx(a_frame), .bin_idx(a_bin), .done(a_done), .ovf(a_ovf));

   sample_frame_counter #(.I_BW(14), .O_BW(16), .FRAME_LEN(FL), .TOTAL_DATA(TD)) dut16 (
      .clk(clk), .rst(rst), .clr(clr), .di_en(di_en), .di_re(di_re), .di_im(di_im),
      .do_en(w_en), .do_re(w_re), .do_im(w_im), .do_sof(w_sof), .do_eof(w_eof),
      .num(w_num), .frame_idx(w_frame), .bin_idx(w_bin), .done(w_done), .ovf(w_ovf));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference: everything derives from k, the number of samples accepted this capture.
   int          m_k = 0;
   bit          m_done = 0, m_ovf = 0, m_en = 0, m_sof = 0, m_eof = 0;
   int          m_num = 0, m_bin = 0, m_frame = 0;
   logic [9:0]  m_re10 = '0, m_im10 = '0;
   logic [15:0] m_re16 = '0, m_im16 = '0;

   function automatic logic [9:0] trunc10(input logic [13:0] x);
      int v;
      v = int'($signed(x));
      return 10'(v >>> 4);
   endfunction

   function automatic logic [15:0] ext16(input logic [13:0] x);
      int v;
      v = int'($signed(x));
      return 16'(v);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_k <= 0; m_done <= 0; m_ovf <= 0; m_en <= 0; m_sof <= 0; m_eof <= 0;
         m_num <= 0; m_bin <= 0; m_frame <= 0;
         m_re10 <= '0; m_im10 <= '0; m_re16 <= '0; m_im16 <= '0;
      end else if (clr) begin
         m_k <= 0; m_done <= 0; m_ovf <= 0; m_en <= 0;
      end else if (di_en && m_done) begin
         m_ovf <= 1; m_en <= 0;
      end else if (di_en) begin
         m_en    <= 1;
         m_num   <= m_k;
         m_bin   <= m_k % FL;
         m_frame <= m_k / FL;
         m_sof   <= (m_k % FL) == 0;
         m_eof   <= ((m_k % FL) == FL - 1) || (m_k == TD - 1);
         m_re10  <= trunc10(di_re); m_im10 <= trunc10(di_im);
         m_re16  <= ext16(di_re);   m_im16 <= ext16(di_im);
         m_k     <= m_k + 1;
         m_done  <= (m_k + 1 == TD);
      end else begin
         m_en <= 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("do_en", a_en, m_en);
         chk("done", a_done, m_done);
         chk("ovf", a_ovf, m_ovf);
         chk("num", a_num, m_num);
         chk("bin_idx", a_bin, m_bin);
         chk("frame_idx", a_frame, m_frame);
         chk("do_re10", a_re, m_re10);
         chk("do_im10", a_im, m_im10);
         chk("do_re16", w_re, m_re16);
         chk("do_im16", w_im, m_im16);
         chk("w_num", w_num, m_num);
         chk("w_en", w_en, m_en);
         if (m_en) begin
            chk("do_sof", a_sof, m_sof);
            chk("do_eof", a_eof, m_eof);
            chk("w_eof", w_eof, m_eof);
            chk("w_sof", w_sof, m_sof);
         end
      end
   end

   // Inputs change 1 time unit after the rising edge; the task returns just after the next one.
   task automatic drive(input bit en, input logic [13:0] re, input bit c);
      di_en = en; di_re = re; di_im = 14'($urandom); clr = c;
      @(posedge clk); #1;
      di_en = 0; clr = 0;
   endtask

   initial begin
      #12;
      chk("rst_do_en", a_en, 0);
      chk("rst_num", a_num, 0);
      chk("rst_done", a_done, 0);
      chk("rst_re", a_re, 0);
      @(posedge clk); #1; rst = 0;

      // back-to-back full capture
      for (int i = 0; i < TD; i++) begin
         drive(1, 14'($urandom), 0);
         if (i == 0) begin
            chk("lit_first_num", a_num, 0);
            chk("lit_first_sof", a_sof, 1);
            chk("lit_first_en", a_en, 1);
         end
         if (i == 4) chk("lit_sof_num4", a_sof, 1);
         if (i == 3) chk("lit_eof_num3", a_eof, 1);
         if (i == 8) chk("lit_done_early", a_done, 0);
      end
      chk("lit_last_num", a_num, 9);
      chk("lit_last_eof", a_eof, 1);
      chk("lit_last_frame", a_frame, 2);
      chk("lit_last_bin", a_bin, 1);
      chk("lit_done", a_done, 1);

      // overrun then restart
      drive(1, 14'd7, 0);
      drive(1, 14'd8, 0);
      chk("lit_ovf_en", a_en, 0);
      chk("lit_ovf", a_ovf, 1);
      chk("lit_ovf_num", a_num, 9);
      drive(0, 14'd0, 1);
      chk("lit_clr_done", a_done, 0);
      chk("lit_clr_ovf", a_ovf, 0);
      chk("lit_clr_num_hold", a_num, 9);
      drive(1, 14'd5, 0);
      chk("lit_restart_num", a_num, 0);
      chk("lit_restart_sof", a_sof, 1);

      // toggling acceptance, data holds between samples
      for (int i = 0; i < 8; i++) begin
         drive(i % 2 == 0, (i % 4 == 0) ? 14'd5 : -14'sd3, 0);
         if (i == 1) chk("lit_hold_re", a_re, 10'(0));
      end
      chk("lit_toggle_num", a_num, 4);

      // clr together with di_en mid-frame
      drive(1, 14'd1, 0);
      chk("lit_num5", a_num, 5);
      drive(1, 14'd2, 1);
      chk("lit_clr_drop", a_en, 0);
      drive(1, 14'd3, 0);
      chk("lit_after_clr_num", a_num, 0);

      // width conversion
      drive(1, 14'h2005, 0);
      chk("lit_trunc", a_re, 10'h200);
      chk("lit_ext2005", w_re, 16'hE005);
      drive(1, 14'h2000, 0);
      chk("lit_ext2000", w_re, 16'hE000);

      // async reset mid-capture
      for (int i = 0; i < 4; i++) drive(1, 14'($urandom), 0);
      chk("lit_pre_rst_num", a_num, 6);
      #3 rst = 1;
      #1;
      chk("lit_arst_num", a_num, 0);
      chk("lit_arst_re", a_re, 0);
      chk("lit_arst_en", a_en, 0);
      @(posedge clk); #1; rst = 0;
      drive(1, 14'($urandom), 0);
      chk("lit_post_rst_num", a_num, 0);

      // random traffic
      for (int i = 0; i < 400; i++)
         drive($urandom_range(99) < 70, 14'($urandom), $urandom_range(99) < 4);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sample_frame_counter.md
Name: sample_frame_counter

Overview:
- Parametrised successor to the pipeline's sample counter.
- Registers the complex sample stream and tags every accepted sample with a global index, a frame index, an in-frame bin index, and start/end-of-frame flags.
- Detects end of capture and flags overrun.
- Sits between the capture front end and the windowing/FFT stage of the log-mel chain; downstream framing logic consumes the tags directly.

Parameters:
- I_BW, 14, input sample width per component (signed).
- O_BW, 14, output sample width per component (signed).
- FRAME_LEN, 512, samples per frame; must be >= 2, any integer value.
- TOTAL_DATA, 91136, samples per capture; must be >= FRAME_LEN.
- NB_W, $clog2(FRAME_LEN), bin index width (derived localparam).
- NF_W, $clog2((TOTAL_DATA+FRAME_LEN-1)/FRAME_LEN), frame index width (derived localparam, minimum 1).
- NT_W, $clog2(TOTAL_DATA), global index width (derived localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous restart of a capture.
- di_en  in  1  input sample valid.
- di_re  in  I_BW  input real, signed.
- di_im  in  I_BW  input imaginary, signed.
- do_en  out  1  output sample valid.
- do_re  out  O_BW  output real.
- do_im  out  O_BW  output imaginary.
- do_sof  out  1  first sample of a frame (qualified by do_en).
- do_eof  out  1  last sample of a frame or of the capture (qualified by do_en).
- num  out  NT_W  zero-based global index of the sample on do_*.
- frame_idx  out  NF_W  zero-based frame number of the sample on do_*.
- bin_idx  out  NB_W  zero-based position within its frame.
- done  out  1  capture complete, sticky.
- ovf  out  1  di_en seen while done, sticky.

Behaviour:
- Reset: rst high asynchronously clears all outputs and internal counters to 0. Release is synchronous to clk.
- Acceptance: a sample is accepted when di_en=1, done=0 and clr=0.
- Latency: 1 cycle. An accepted sample appears on do_* with do_en=1 in the next cycle. In cycles with no acceptance, do_en=0.
- Hold: do_re, do_im, num, frame_idx, bin_idx, do_sof and do_eof change only on acceptance and hold otherwise. do_sof and do_eof are meaningful only while do_en=1.
- Width conversion, applied per component:
  - O_BW >= I_BW: sign-extend.
  - O_BW < I_BW: keep the top O_BW bits (arithmetic truncation of LSBs, no rounding).
- Index counters: internal next-index counters t (0..TOTAL_DATA-1), b (0..FRAME_LEN-1) and f start at 0. On acceptance:
  - num <= t, bin_idx <= b, frame_idx <= f.
  - do_sof <= (b==0).
  - do_eof <= (b==FRAME_LEN-1) or (t==TOTAL_DATA-1).
  - Then t increments. b wraps to 0 at FRAME_LEN-1, and f increments on that wrap.
- Partial frame: when TOTAL_DATA is not a multiple of FRAME_LEN, the final frame is short; do_eof is still asserted on sample TOTAL_DATA-1.
- Done: on accepting sample TOTAL_DATA-1, done rises in the same cycle that sample's do_en is high. done stays high until clr or rst. Counters stop at their final values.
- Overrun: di_en=1 while done=1 is dropped (no do_en) and sets ovf, which is sticky until clr or rst.
- clr: synchronous, highest priority below rst. It zeroes t, b, f, done and ovf, forces do_en=0 in the next cycle, and drops any di_en in the same cycle. do_re, do_im and the index outputs hold their values.
- Stalls: gaps in di_en are arbitrary; no index advances without acceptance.
- Mid-capture reset: rst asserted mid-capture restarts the capture from index 0 after release.

Test Plan:
- FRAME_LEN=4, TOTAL_DATA=10, 10 back-to-back di_en -> do_en 1 cycle later. bin_idx 0,1,2,3,0,1,2,3,0,1. frame_idx 0,0,0,0,1,1,1,1,2,2. do_sof at num 0,4,8. do_eof at num 3,7,9. done rises with num=9.
- Same config, di_en toggling 1,0,1,0 with di_re=5,-3,... -> indices advance only on accepted samples; do_re holds between them; num sequence is contiguous with no gaps.
- After done, drive 2 more di_en -> do_en stays 0, ovf=1, num holds at 9. Then clr=1 for 1 cycle -> done=0, ovf=0; next accepted sample gives num=0, do_sof=1.
- clr and di_en high in the same cycle mid-frame (num=5) -> that sample is dropped; the next accepted sample gives num=0.
- I_BW=14, O_BW=10, di_re=14'h2005 (negative) -> do_re=10'h200. Then O_BW=16, di_re=14'h2000 -> do_re=16'hE000.
- rst pulsed high asynchronously between clock edges at num=6 -> all outputs 0 immediately; after release, a capture restarts from num=0.
